// File: rtl/traffic_sequencer.sv
// rtl/traffic_sequencer.sv - actuated two-way intersection controller with ped walk and main-road preempt
module traffic_sequencer #(
    parameter int G1_MIN    = 20,
    parameter int G2_TIME   = 10,
    parameter int Y_TIME    = 3,
    parameter int AR_TIME   = 1,
    parameter int WALK_TIME = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       car2,
    input  logic       ped_btn,
    input  logic       preempt,
    output logic       r1,
    output logic       y1,
    output logic       g1,
    output logic       r2,
    output logic       y2,
    output logic       g2,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] state
);

    localparam int MAX_A = (G1_MIN > G2_TIME) ? G1_MIN : G2_TIME;
    localparam int MAX_B = (Y_TIME > AR_TIME) ? Y_TIME : AR_TIME;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAXP  = (MAX_C > WALK_TIME) ? MAX_C : WALK_TIME;
    localparam int TW    = $clog2(MAXP) + 1;

    localparam logic [TW-1:0] G1_LAST   = TW'(G1_MIN - 1);
    localparam logic [TW-1:0] G2_LAST   = TW'(G2_TIME - 1);
    localparam logic [TW-1:0] Y_LAST    = TW'(Y_TIME - 1);
    localparam logic [TW-1:0] AR_LAST   = TW'(AR_TIME - 1);
    localparam logic [TW-1:0] WALK_LAST = TW'(WALK_TIME - 1);

    typedef enum logic [2:0] {
        S_ALLRED = 3'd0,
        S_G1     = 3'd1,
        S_Y1     = 3'd2,
        S_AR1    = 3'd3,
        S_WALK   = 3'd4,
        S_G2     = 3'd5,
        S_Y2     = 3'd6,
        S_AR2    = 3'd7
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] timer;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_ALLRED;
        end else begin
            state_q <= state_d;
        end
    end

    // cycles-in-state counter; restarts on every state change, parks at the end of minimum main green
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (state_d != state_q) begin
            timer <= '0;
        end else if (!(state_q == S_G1 && timer == G1_LAST)) begin
            timer <= timer + 1'b1;
        end
    end

    // pedestrian request latch; served (and any same-cycle press absorbed) on WALK entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ped_pending <= 1'b0;
        end else if (state_d == S_WALK && state_q != S_WALK) begin
            ped_pending <= 1'b0;
        end else if (ped_btn) begin
            ped_pending <= 1'b1;
        end
    end

    // next-state selection; preempt overrides the timer in WALK and G2
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_ALLRED: if (timer == AR_LAST) state_d = S_G1;
            S_G1: begin
                if (timer == G1_LAST && (car2 || ped_pending) && !preempt) state_d = S_Y1;
            end
            S_Y1: if (timer == Y_LAST) state_d = S_AR1;
            S_AR1: begin
                if (timer == AR_LAST) begin
                    if (preempt)          state_d = S_G1;
                    else if (ped_pending) state_d = S_WALK;
                    else                  state_d = S_G2;
                end
            end
            S_WALK: begin
                if (preempt)                state_d = S_AR2;
                else if (timer == WALK_LAST) state_d = car2 ? S_G2 : S_AR2;
            end
            S_G2: begin
                if (preempt || timer == G2_LAST) state_d = S_Y2;
            end
            S_Y2:  if (timer == Y_LAST) state_d = S_AR2;
            S_AR2: if (timer == AR_LAST) state_d = S_G1;
            default: state_d = S_ALLRED;
        endcase
    end

    // Moore lamp decode from the state register
    always_comb begin
        r1   = 1'b0;
        y1   = 1'b0;
        g1   = 1'b0;
        r2   = 1'b0;
        y2   = 1'b0;
        g2   = 1'b0;
        walk = 1'b0;
        unique case (state_q)
            S_G1:   begin g1 = 1'b1; r2 = 1'b1; end
            S_Y1:   begin y1 = 1'b1; r2 = 1'b1; end
            S_WALK: begin r1 = 1'b1; r2 = 1'b1; walk = 1'b1; end
            S_G2:   begin r1 = 1'b1; g2 = 1'b1; end
            S_Y2:   begin r1 = 1'b1; y2 = 1'b1; end
            default: begin r1 = 1'b1; r2 = 1'b1; end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_traffic_sequencer.sv
// tb/tb_traffic_sequencer.sv - table-driven directed bench for traffic_sequencer
module tb_traffic_sequencer;

    localparam logic [2:0] ALLRED = 3'd0, G1 = 3'd1, Y1 = 3'd2, AR1 = 3'd3,
                           WALK = 3'd4, G2 = 3'd5, Y2 = 3'd6, AR2 = 3'd7;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       car2 = 1'b0;
    logic       ped_btn = 1'b0;
    logic       preempt = 1'b0;
    logic       r1, y1, g1, r2, y2, g2, walk, ped_pending;
    logic [2:0] state;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic       car2;
        logic       ped;
        logic       pre;
        int         n;
        logic [2:0] st;
        logic       pp;
    } vec_t;

    vec_t tbl[$];

    traffic_sequencer dut (
        .clk(clk), .reset_n(reset_n), .car2(car2), .ped_btn(ped_btn), .preempt(preempt),
        .r1(r1), .y1(y1), .g1(g1), .r2(r2), .y2(y2), .g2(g2), .walk(walk),
        .ped_pending(ped_pending), .state(state)
    );

    always #5 clk = ~clk;

    // expected {r1,y1,g1,r2,y2,g2,walk} for a state code
    function automatic logic [6:0] lamps_for(input logic [2:0] s);
        case (s)
            G1:      return 7'b0011000;
            Y1:      return 7'b0101000;
            WALK:    return 7'b1001001;
            G2:      return 7'b1000010;
            Y2:      return 7'b1000100;
            default: return 7'b1001000;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] exp_st, input logic exp_pp);
        check({tag, " state"}, int'(state), int'(exp_st));
        check({tag, " lamps"}, int'({r1, y1, g1, r2, y2, g2, walk}), int'(lamps_for(exp_st)));
        check({tag, " ped_pending"}, int'(ped_pending), int'(exp_pp));
    endtask

    task automatic add(input logic c, input logic p, input logic e, input int n,
                       input logic [2:0] st, input logic pp);
        vec_t v;
        v.car2 = c; v.ped = p; v.pre = e; v.n = n; v.st = st; v.pp = pp;
        tbl.push_back(v);
    endtask

    initial begin
        // rest in main green
        add(0, 0, 0, 100, G1, 0);
        // side road service from a saturated main green, then a full 38-cycle repeat
        add(1, 0, 0, 3, Y1, 0);   add(1, 0, 0, 1, AR1, 0); add(1, 0, 0, 10, G2, 0);
        add(1, 0, 0, 3, Y2, 0);   add(1, 0, 0, 1, AR2, 0); add(1, 0, 0, 20, G1, 0);
        add(1, 0, 0, 3, Y1, 0);   add(1, 0, 0, 1, AR1, 0); add(1, 0, 0, 10, G2, 0);
        add(1, 0, 0, 3, Y2, 0);   add(1, 0, 0, 1, AR2, 0);
        // pedestrian press at main-green cycle 5
        add(0, 0, 0, 5, G1, 0);   add(0, 1, 0, 1, G1, 1);  add(0, 0, 0, 14, G1, 1);
        add(0, 0, 0, 3, Y1, 1);   add(0, 0, 0, 1, AR1, 1); add(0, 0, 0, 8, WALK, 0);
        add(0, 0, 0, 1, AR2, 0);
        // preempt raised at side-green cycle 4
        add(1, 0, 0, 20, G1, 0);  add(1, 0, 0, 3, Y1, 0);  add(1, 0, 0, 1, AR1, 0);
        add(1, 0, 0, 4, G2, 0);   add(1, 0, 1, 3, Y2, 0);  add(1, 0, 1, 1, AR2, 0);
        add(1, 0, 1, 25, G1, 0);
        // preempt drop: main green exits at once; press during Y1, preempt at AR1 exit
        add(1, 1, 0, 1, Y1, 1);   add(1, 0, 0, 2, Y1, 1);  add(1, 0, 1, 1, AR1, 1);
        add(1, 0, 1, 22, G1, 1);
        // after preempt drops, the held walk is served
        add(0, 0, 0, 3, Y1, 1);   add(0, 0, 0, 1, AR1, 1); add(0, 0, 0, 8, WALK, 0);
        add(0, 0, 0, 1, AR2, 0);  add(0, 0, 0, 2, G1, 0);

        // reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        check_all("reset held", ALLRED, 1'b0);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            car2    = tbl[i].car2;
            ped_btn = tbl[i].ped;
            preempt = tbl[i].pre;
            for (int j = 0; j < tbl[i].n; j++) begin
                @(posedge clk);
                #1;
                check_all($sformatf("vec%0d cyc%0d", i, j), tbl[i].st, tbl[i].pp);
                ped_btn = 1'b0;
            end
        end

        // asynchronous reset asserted between edges during Y2
        car2 = 1'b1;
        begin
            int cyc = 0;
            while (state != Y2 && cyc < 100) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            check("reach Y2", int'(state), int'(Y2));
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_all("async reset in Y2", ALLRED, 1'b0);
        @(posedge clk);
        #1;
        check_all("reset held 2", ALLRED, 1'b0);
        reset_n = 1'b1;
        car2    = 1'b0;
        @(posedge clk);
        #1;
        check_all("after release", G1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
